// File: rtl/vga_pkg.sv
// Shared VGA definitions: standard 640x480@60 timing, polarity codes,
// totals helper and the play-area geometry used by the renderers.
package vga_pkg;

  localparam int STD_H_DISPLAY = 640;
  localparam int STD_H_FRONT   = 16;
  localparam int STD_H_SYNC    = 96;
  localparam int STD_H_BACK    = 48;
  localparam int STD_V_DISPLAY = 480;
  localparam int STD_V_FRONT   = 10;
  localparam int STD_V_SYNC    = 2;
  localparam int STD_V_BACK    = 33;
  localparam int STD_CLK_DIV   = 4;

  localparam bit POL_LOW  = 1'b0;
  localparam bit POL_HIGH = 1'b1;

  localparam int PLAY_X0     = 220;
  localparam int PLAY_Y0     = 240;
  localparam int PLAY_W      = 200;
  localparam int PLAY_H      = 140;
  localparam int PLAY_BORDER = 5;
  localparam int HP_BAR_X0   = 220;
  localparam int HP_BAR_Y0   = 400;
  localparam int HP_BAR_W    = 100;
  localparam int HP_BAR_H    = 20;

  typedef struct packed {
    logic hs;
    logic vs;
    logic vis;
  } sync_t;

  function automatic int total(
    input int disp,
    input int front,
    input int sync,
    input int back
  );
    return disp + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Pixel-tick aligned shift register; DEPTH=0 passes the input straight through.
// Stages reset to IDLE and only move when shift is high.
module vga_delay_line #(
  parameter int               WIDTH = 3,
  parameter int               DEPTH = 0,
  parameter logic [WIDTH-1:0] IDLE  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_pass
    logic unused;
    assign unused = &{1'b0, clk, reset, shift};
    assign dout = din;
  end else begin : g_stages
    logic [WIDTH-1:0] stg [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < DEPTH; i++) begin
          stg[i] <= IDLE;
        end
      end else if (shift) begin
        stg[0] <= din;
        for (int i = 1; i < DEPTH; i++) begin
          stg[i] <= stg[i-1];
        end
      end
    end

    assign dout = stg[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel-tick divider,
// frame counter and a tick-aligned delay on the sync/visible flags.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = STD_CLK_DIV,
  parameter int H_DISPLAY = STD_H_DISPLAY,
  parameter int H_FRONT   = STD_H_FRONT,
  parameter int H_SYNC    = STD_H_SYNC,
  parameter int H_BACK    = STD_H_BACK,
  parameter int V_DISPLAY = STD_V_DISPLAY,
  parameter int V_FRONT   = STD_V_FRONT,
  parameter int V_SYNC    = STD_V_SYNC,
  parameter int V_BACK    = STD_V_BACK,
  parameter bit H_POL     = POL_LOW,
  parameter bit V_POL     = POL_LOW,
  parameter int CW        = 10,
  parameter int DELAY     = 0,
  parameter int FRAME_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  output logic               p_tick,
  output logic [CW-1:0]      x,
  output logic [CW-1:0]      y,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int H_TOTAL = total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  if ((2 ** CW) < H_TOTAL || (2 ** CW) < V_TOTAL) begin : g_cw_check
    $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
  end

  if (CLK_DIV < 1) begin : g_div_check
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_DISPLAY);
  localparam logic [CW-1:0] V_VIS    = CW'(V_DISPLAY);
  localparam logic [CW-1:0] HS_ON    = CW'(H_DISPLAY + H_FRONT);
  localparam logic [CW-1:0] HS_OFF   = CW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [CW-1:0] VS_ON    = CW'(V_DISPLAY + V_FRONT);
  localparam logic [CW-1:0] VS_OFF   = CW'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DW-1:0]      div_cnt;
  logic [CW-1:0]      h;
  logic [CW-1:0]      v;
  logic [FRAME_W-1:0] fc;
  logic               h_wrap;
  logic               v_wrap;
  sync_t              raw;
  sync_t              dly;

  assign p_tick = en && !reset && (div_cnt == '0);
  assign h_wrap = (h == H_LAST);
  assign v_wrap = (v == V_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (en) begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h  <= '0;
      v  <= '0;
      fc <= '0;
    end else if (p_tick) begin
      h <= h_wrap ? '0 : h + CW'(1);
      if (h_wrap) begin
        v <= v_wrap ? '0 : v + CW'(1);
        if (v_wrap) begin
          fc <= fc + FRAME_W'(1);
        end
      end
    end
  end

  // Raw flags are forced idle under reset so DELAY=0 also shows idle outputs.
  always_comb begin
    raw     = '0;
    raw.vis = !reset && (h < H_VIS) && (v < V_VIS);
    raw.hs  = !reset && (h >= HS_ON) && (h <= HS_OFF);
    raw.vs  = !reset && (v >= VS_ON) && (v <= VS_OFF);
  end

  vga_delay_line #(
    .WIDTH ($bits(sync_t)),
    .DEPTH (DELAY),
    .IDLE  ('0)
  ) u_delay (
    .clk   (clk),
    .reset (reset),
    .shift (p_tick),
    .din   (raw),
    .dout  (dly)
  );

  assign hsync       = dly.hs ? H_POL : ~H_POL;
  assign vsync       = dly.vs ? V_POL : ~V_POL;
  assign video_on    = dly.vis;
  assign line_start  = p_tick && (h == '0);
  assign frame_start = line_start && (v == '0);
  assign frame_count = fc;
  assign x           = h;
  assign y           = v;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances against a tick-count model
// under random run-enable, a 37-clock hold and an async mid-frame reset.
module tb_vga_timing_gen;

  localparam int SHD = 20, SHF = 3, SHS = 4, SHB = 5;
  localparam int SVD = 10, SVF = 2, SVS = 2, SVB = 3;
  localparam int SCW = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   e_cnt = 0;

  always #5 clk = ~clk;

  logic            p0, hs0, vs0, vo0, ls0, fs0;
  logic [SCW-1:0]  x0, y0;
  logic [1:0]      fc0;
  logic            p1, hs1, vs1, vo1, ls1, fs1;
  logic [SCW-1:0]  x1, y1;
  logic [7:0]      fc1;
  logic            p2, hs2, vs2, vo2, ls2, fs2;
  logic [9:0]      x2, y2;
  logic [7:0]      fc2;

  vga_timing_gen #(
    .CLK_DIV(3), .H_DISPLAY(SHD), .H_FRONT(SHF), .H_SYNC(SHS),
    .H_BACK(SHB), .V_DISPLAY(SVD), .V_FRONT(SVF), .V_SYNC(SVS),
    .V_BACK(SVB), .H_POL(1'b0), .V_POL(1'b0), .CW(SCW),
    .DELAY(0), .FRAME_W(2)
  ) d0 (
    .clk(clk), .reset(reset), .en(en), .p_tick(p0), .x(x0), .y(y0),
    .hsync(hs0), .vsync(vs0), .video_on(vo0), .line_start(ls0),
    .frame_start(fs0), .frame_count(fc0)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_DISPLAY(SHD), .H_FRONT(SHF), .H_SYNC(SHS),
    .H_BACK(SHB), .V_DISPLAY(SVD), .V_FRONT(SVF), .V_SYNC(SVS),
    .V_BACK(SVB), .H_POL(1'b1), .V_POL(1'b1), .CW(SCW),
    .DELAY(2), .FRAME_W(8)
  ) d1 (
    .clk(clk), .reset(reset), .en(en), .p_tick(p1), .x(x1), .y(y1),
    .hsync(hs1), .vsync(vs1), .video_on(vo1), .line_start(ls1),
    .frame_start(fs1), .frame_count(fc1)
  );

  vga_timing_gen d2 (
    .clk(clk), .reset(reset), .en(en), .p_tick(p2), .x(x2), .y(y2),
    .hsync(hs2), .vsync(vs2), .video_on(vo2), .line_start(ls2),
    .frame_start(fs2), .frame_count(fc2)
  );

  typedef struct packed {
    logic [31:0] x, y, fc;
    logic pt, ls, fs, hs, vs, vo;
  } exp_t;

  // Expected outputs from the number of enabled clocks since reset.
  function automatic exp_t model(
    input int cd, input int hd, input int hf, input int hs,
    input int hb, input int vd, input int vf, input int vs,
    input int vb, input bit hp, input bit vp, input int dly,
    input int fw, input int e, input bit en_now, input bit rst
  );
    exp_t m;
    int ht, vt, t, rt, rh, rv;
    bit r_hs, r_vs, r_vo;
    ht = hd + hf + hs + hb;
    vt = vd + vf + vs + vb;
    m = '0;
    m.hs = !hp;
    m.vs = !vp;
    if (rst) return m;
    t = (e + cd - 1) / cd;
    m.pt = en_now && (e % cd == 0);
    m.x = 32'(t % ht);
    m.y = 32'((t / ht) % vt);
    m.fc = 32'((t / (ht * vt)) % (1 << fw));
    m.ls = m.pt && (m.x == 0);
    m.fs = m.ls && (m.y == 0);
    r_hs = 0;
    r_vs = 0;
    r_vo = 0;
    if (t >= dly) begin
      rt = t - dly;
      rh = rt % ht;
      rv = (rt / ht) % vt;
      r_hs = (rh >= hd + hf) && (rh < hd + hf + hs);
      r_vs = (rv >= vd + vf) && (rv < vd + vf + vs);
      r_vo = (rh < hd) && (rv < vd);
    end
    m.hs = r_hs ? hp : !hp;
    m.vs = r_vs ? vp : !vp;
    m.vo = r_vo;
    return m;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s e=%0d got=%0h want=%0h", tag, e_cnt, got, want);
    end
  endtask

  task automatic check_all();
    exp_t m;
    m = model(3, SHD, SHF, SHS, SHB, SVD, SVF, SVS, SVB,
              1'b0, 1'b0, 0, 2, e_cnt, en, reset);
    cmp("d0.p_tick", 32'(p0), 32'(m.pt));
    cmp("d0.x", 32'(x0), m.x);
    cmp("d0.y", 32'(y0), m.y);
    cmp("d0.fc", 32'(fc0), m.fc);
    cmp("d0.ls", 32'(ls0), 32'(m.ls));
    cmp("d0.fs", 32'(fs0), 32'(m.fs));
    cmp("d0.hsync", 32'(hs0), 32'(m.hs));
    cmp("d0.vsync", 32'(vs0), 32'(m.vs));
    cmp("d0.video_on", 32'(vo0), 32'(m.vo));
    m = model(1, SHD, SHF, SHS, SHB, SVD, SVF, SVS, SVB,
              1'b1, 1'b1, 2, 8, e_cnt, en, reset);
    cmp("d1.p_tick", 32'(p1), 32'(m.pt));
    cmp("d1.x", 32'(x1), m.x);
    cmp("d1.y", 32'(y1), m.y);
    cmp("d1.fc", 32'(fc1), m.fc);
    cmp("d1.ls", 32'(ls1), 32'(m.ls));
    cmp("d1.fs", 32'(fs1), 32'(m.fs));
    cmp("d1.hsync", 32'(hs1), 32'(m.hs));
    cmp("d1.vsync", 32'(vs1), 32'(m.vs));
    cmp("d1.video_on", 32'(vo1), 32'(m.vo));
    m = model(4, 640, 16, 96, 48, 480, 10, 2, 33,
              1'b0, 1'b0, 0, 8, e_cnt, en, reset);
    cmp("d2.p_tick", 32'(p2), 32'(m.pt));
    cmp("d2.x", 32'(x2), m.x);
    cmp("d2.y", 32'(y2), m.y);
    cmp("d2.fc", 32'(fc2), m.fc);
    cmp("d2.ls", 32'(ls2), 32'(m.ls));
    cmp("d2.fs", 32'(fs2), 32'(m.fs));
    cmp("d2.hsync", 32'(hs2), 32'(m.hs));
    cmp("d2.vsync", 32'(vs2), 32'(m.vs));
    cmp("d2.video_on", 32'(vo2), 32'(m.vo));
  endtask

  // Called just after a falling edge; returns at the next falling edge.
  task automatic step(input bit en_v);
    en = en_v;
    #1;
    check_all();
    @(posedge clk);
    if (en && !reset) e_cnt++;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    step(1'b1);
    step(1'b0);
    reset = 1'b0;
    e_cnt = 0;

    for (int i = 0; i < 300; i++) step(1'b1);
    for (int i = 0; i < 37; i++) step(1'b0);
    for (int i = 0; i < 20; i++) step(1'b1);

    for (int i = 0; i < 9000; i++) step(($urandom % 8) != 0);

    // Asynchronous reset well away from either clock edge.
    #2;
    reset = 1'b1;
    #1;
    check_all();
    @(negedge clk);
    step(1'b1);
    reset = 1'b0;
    e_cnt = 0;
    for (int i = 0; i < 200; i++) step(1'b1);
    for (int i = 0; i < 200; i++) step(($urandom % 4) != 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator. Successor to the fixed 640x480 sync unit.
- Provides:
  - a pixel-tick divider;
  - horizontal and vertical counters with a programmable timing geometry;
  - selectable sync polarity;
  - a video_on flag;
  - line-start and frame-start strobes and a frame counter;
  - a pixel-tick-aligned delay line on hsync, vsync and video_on, to match renderer and sprite-ROM pipeline latency.
- Sits between the system clock and the renderers (play area, heart sprite, bullets, HP bar).

Parameters:
- CLK_DIV, 4, system clocks per pixel tick (>=1).
- H_DISPLAY, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch (pixels).
- H_SYNC, 96, horizontal sync width (pixels).
- H_BACK, 48, horizontal back porch (pixels).
- V_DISPLAY, 480, visible lines.
- V_FRONT, 10, vertical front porch (lines).
- V_SYNC, 2, vertical sync width (lines).
- V_BACK, 33, vertical back porch (lines).
- H_POL, 0, active level of hsync (0 = active-low).
- V_POL, 0, active level of vsync.
- CW, 10, counter width. Elaboration error if 2^CW < H_TOTAL or 2^CW < V_TOTAL.
- DELAY, 0, pixel ticks of delay applied to hsync, vsync and video_on.
- FRAME_W, 8, frame counter width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- en  in  1  run enable; low freezes all timing state.
- p_tick  out  1  pixel-tick strobe.
- x  out  CW  current horizontal count.
- y  out  CW  current vertical count.
- hsync  out  1  horizontal sync, polarity H_POL, delayed DELAY ticks.
- vsync  out  1  vertical sync, polarity V_POL, delayed DELAY ticks.
- video_on  out  1  visible-region flag, delayed DELAY ticks.
- line_start  out  1  strobe at pixel tick of h=0.
- frame_start  out  1  strobe at pixel tick of (h,v)=(0,0).
- frame_count  out  FRAME_W  completed frames, wrapping.

Behaviour:
- Derived totals: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK; V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK.
- Region order is display, front porch, sync, back porch on both axes.
- Reset (async, immediate, including mid-frame) sets:
  - div_cnt=0, h=0, v=0, frame_count=0;
  - all delay stages inactive: hsync=~H_POL, vsync=~V_POL, video_on=0.
  - p_tick, line_start and frame_start are 0 while reset is high.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 on each clk while en=1.
  - p_tick = en && div_cnt==0 (combinational from the register).
  - CLK_DIV=1 gives p_tick=1 on every enabled cycle.
  - First p_tick occurs on the first clk after reset release with en=1.
- Counters, updated on p_tick only:
  - h increments and wraps H_TOTAL-1 -> 0.
  - On h wrap, v increments and wraps V_TOTAL-1 -> 0.
  - On v wrap, frame_count increments, wrapping modulo 2^FRAME_W.
  - x=h and y=v, undelayed.
- en=0: div_cnt, counters, frame_count and delay line all hold; p_tick=0, so both strobes are 0. Resuming continues from the held state, with no skipped pixels.
- Raw decode from the counter registers:
  - vis = h<H_DISPLAY && v<V_DISPLAY.
  - hs_act = h in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1].
  - vs_act = v in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1].
- Strobes:
  - line_start = p_tick && h==0.
  - frame_start = p_tick && h==0 && v==0.
  - Each is one clk wide.
- Delay line:
  - DELAY=0: outputs are the raw decode, with polarity applied (hsync = hs_act ? H_POL : ~H_POL; vsync likewise with V_POL).
  - DELAY=N: N register stages of {hs_act, vs_act, vis}, all shifted on p_tick only.
  - Output equals the raw value from N ticks earlier.
  - Stages hold while en=0.
- All arithmetic is unsigned at CW bits. Compare constants are computed at elaboration.

Decomposition:
- Shared package vga_pkg holds:
  - the standard 640x480@60 timing constants;
  - the H_TOTAL/V_TOTAL derivation function;
  - the polarity encodings;
  - the play-area geometry constants used by the renderers.
- One sub-module, vga_delay_line:
  - parameter WIDTH and DEPTH;
  - shift on enable;
  - async reset to a parameterised idle vector;
  - DEPTH=0 is a pass-through.

Test Plan:
- Defaults, reset released, en=1 -> p_tick every 4th clk. h runs 0..799 and wraps. v increments on wrap. x/y track exactly.
- Defaults -> hsync low for exactly 96 ticks starting h=656, vsync low for lines 490-491, video_on high for exactly 640x480 ticks per frame. With H_POL=1 the hsync waveform is inverted.
- FRAME_W=2, 5 frames -> frame_start pulses exactly 420000 ticks apart; frame_count goes 1,2,3,0,1. line_start count per frame is 525.
- DELAY=2 -> video_on rises 2 ticks after the (0,0) tick, and hsync edges occur at h=658 and h=754. DELAY=0 reference capture matches when shifted by 2 ticks.
- en dropped for 37 clks at h=300,v=200 -> no p_tick, x/y/frame_count/delay stages frozen. After resume the next tick gives h=301.
- reset pulsed asynchronously at h=300,v=200 -> same-cycle x=0, y=0, hsync=vsync=1 (defaults), video_on=0. The first p_tick after release leads to h=1.
